// File: rtl/game_timer.sv
// Per-round game clock: divides clk into one-second ticks and counts elapsed seconds up to GAME_SECONDS.
// Optional bonus (add_time port) is enabled by defining TIMER_BONUS_EN.
module game_timer #(
    parameter int unsigned CLK_HZ        = 100000000,
    parameter int unsigned GAME_SECONDS  = 30,
    parameter int unsigned BONUS_SECONDS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause_toggle,
    input  logic       stop,
`ifdef TIMER_BONUS_EN
    input  logic       add_time,
`endif
    output logic [4:0] elapsed_time,
    output logic       running,
    output logic       sec_tick,
    output logic       time_up
);

    localparam int unsigned PS_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned EL_W  = 5;
    localparam int unsigned SUM_W = EL_W + 1;

    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(CLK_HZ - 1);
    localparam logic [EL_W-1:0]  EL_MAX  = EL_W'(GAME_SECONDS);
    localparam logic [SUM_W-1:0] BONUS   = SUM_W'(BONUS_SECONDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PS_W-1:0]  ps_q, ps_d;
    logic [EL_W-1:0]  el_q, el_d;
    logic             running_d, sec_tick_d, time_up_d;
    logic             tick_c;
    logic             add_c;
    logic [SUM_W-1:0] sum_c;

    // Without the bonus feature the add path is tied off and folds away.
`ifdef TIMER_BONUS_EN
    assign add_c = add_time;
`else
    assign add_c = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ps_q     <= '0;
            el_q     <= '0;
            running  <= 1'b0;
            sec_tick <= 1'b0;
            time_up  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ps_q     <= ps_d;
            el_q     <= el_d;
            running  <= running_d;
            sec_tick <= sec_tick_d;
            time_up  <= time_up_d;
        end
    end

    assign elapsed_time = el_q;

    // Next-state: stop beats start beats pause_toggle; prescaler advances only in RUN.
    always_comb begin
        state_d    = state_q;
        ps_d       = ps_q;
        el_d       = el_q;
        sec_tick_d = 1'b0;
        time_up_d  = 1'b0;
        sum_c      = '0;
        tick_c     = (state_q == RUN) && (ps_q == PS_LAST);

        if (stop) begin
            state_d = IDLE;
            ps_d    = '0;
            el_d    = '0;
        end else if (start) begin
            state_d = RUN;
            ps_d    = '0;
            el_d    = '0;
        end else begin
            case (state_q)
                RUN: begin
                    ps_d       = tick_c ? '0 : ps_q + PS_W'(1);
                    el_d       = el_q + EL_W'(tick_c);
                    sec_tick_d = tick_c;
                    if (pause_toggle) state_d = PAUSED;
                end
                PAUSED: begin
                    if (pause_toggle) state_d = RUN;
                end
                default: ;
            endcase

            // Bonus subtracts from the post-tick count, saturating at zero.
            if (add_c && (state_q == RUN || state_q == PAUSED)) begin
                sum_c = {1'b0, el_q} + SUM_W'(tick_c);
                el_d  = (sum_c > BONUS) ? EL_W'(sum_c - BONUS) : '0;
            end

            if (state_q == RUN && el_d == EL_MAX) begin
                state_d   = DONE;
                time_up_d = 1'b1;
            end
        end

        running_d = (state_d == RUN);
    end

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer (CLK_HZ=4, GAME_SECONDS=3) with a cycle-counting reference model.
module tb_game_timer;

    localparam int unsigned CLK_HZ = 4;
    localparam int unsigned GAME   = 3;
    localparam int unsigned BONUS  = 3;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, pause_toggle = 1'b0, stop = 1'b0, add_time = 1'b0;
    logic [4:0] elapsed_time;
    logic       running, sec_tick, time_up;

    int checks = 0;
    int errors = 0;

    game_timer #(.CLK_HZ(CLK_HZ), .GAME_SECONDS(GAME), .BONUS_SECONDS(BONUS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .pause_toggle (pause_toggle),
        .stop         (stop),
`ifdef TIMER_BONUS_EN
        .add_time     (add_time),
`endif
        .elapsed_time (elapsed_time),
        .running      (running),
        .sec_tick     (sec_tick),
        .time_up      (time_up)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: counts cycles spent running; every CLK_HZ-th running cycle is a second.
    int m_mode = M_IDLE, m_run = 0, m_el = 0;
    bit m_tick = 0, m_up = 0;

    always @(posedge clk or negedge rst_n) begin : model
        int mode, run, el;
        bit tk, up, add;
        if (!rst_n) begin
            m_mode <= M_IDLE; m_run <= 0; m_el <= 0; m_tick <= 0; m_up <= 0;
        end else begin
            mode = m_mode; run = m_run; el = m_el; tk = 0; up = 0;
`ifdef TIMER_BONUS_EN
            add = add_time;
`else
            add = 0;
`endif
            if (stop) begin
                mode = M_IDLE; run = 0; el = 0;
            end else if (start) begin
                mode = M_RUN; run = 0; el = 0;
            end else begin
                if (m_mode == M_RUN) begin
                    run = run + 1;
                    tk  = (run % CLK_HZ) == 0;
                    if (tk) el = el + 1;
                    if (pause_toggle) mode = M_PAUSED;
                end else if (m_mode == M_PAUSED && pause_toggle) begin
                    mode = M_RUN;
                end
                if (add && (m_mode == M_RUN || m_mode == M_PAUSED))
                    el = (el > int'(BONUS)) ? el - int'(BONUS) : 0;
                if (m_mode == M_RUN && el == int'(GAME)) begin
                    mode = M_DONE; up = 1;
                end
            end
            m_mode <= mode; m_run <= run; m_el <= el; m_tick <= tk; m_up <= up;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        check("elapsed_time", int'(elapsed_time), m_el);
        check("running",      int'(running),      int'(m_mode == M_RUN));
        check("sec_tick",     int'(sec_tick),     int'(m_tick));
        check("time_up",      int'(time_up),      int'(m_up));
    end

    // Each task call starts and ends just after a falling edge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic s, input logic p, input logic t, input logic a);
        start = s; pause_toggle = p; stop = t; add_time = a;
        @(negedge clk);
        start = 0; pause_toggle = 0; stop = 0; add_time = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle(3);
        rst_n = 1'b1;

        // 1: idle after reset
        idle(10);
        check("t1 elapsed", int'(elapsed_time), 0);
        check("t1 running", int'(running), 0);
        check("t1 time_up", int'(time_up), 0);

        // 2: full round
        pulse(1, 0, 0, 0);                       // after edge N
        check("t2 running@N", int'(running), 1);
        idle(4);
        check("t2 el@N+4", int'(elapsed_time), 1);
        check("t2 tick@N+4", int'(sec_tick), 1);
        idle(4);
        check("t2 el@N+8", int'(elapsed_time), 2);
        idle(3);
        check("t2 up@N+11", int'(time_up), 0);
        idle(1);
        check("t2 el@N+12", int'(elapsed_time), 3);
        check("t2 up@N+12", int'(time_up), 1);
        check("t2 run@N+12", int'(running), 0);
        idle(5);
        check("t2 el hold", int'(elapsed_time), 3);
        check("t2 up once", int'(time_up), 0);
        pulse(0, 1, 0, 0);                       // pause ignored in DONE
        check("t2 done pause", int'(running), 0);

        // 3: pause for 10 cycles
        pulse(1, 0, 0, 0);
        idle(1);
        pulse(0, 1, 0, 0);                       // sampled at N+2
        check("t3 paused", int'(running), 0);
        idle(9);
        pulse(0, 1, 0, 0);                       // sampled at N+12
        check("t3 el@N+12", int'(elapsed_time), 0);
        check("t3 resumed", int'(running), 1);
        idle(1);
        check("t3 el@N+13", int'(elapsed_time), 0);
        idle(1);
        check("t3 el@N+14", int'(elapsed_time), 1);
        idle(7);
        check("t3 up@N+21", int'(time_up), 0);
        idle(1);
        check("t3 up@N+22", int'(time_up), 1);

        // 4: priority
        pulse(1, 0, 0, 0);
        idle(5);
        check("t4 el mid", int'(elapsed_time), 1);
        pulse(1, 0, 1, 0);
        check("t4 stop el", int'(elapsed_time), 0);
        check("t4 stop run", int'(running), 0);
        pulse(1, 0, 0, 0);
        check("t4 restart", int'(running), 1);
        idle(2);
        pulse(1, 1, 0, 0);
        check("t4 start+pause", int'(running), 1);
        idle(4);
        check("t4 el after", int'(elapsed_time), 1);

        // 5: async reset mid-count
        pulse(1, 0, 0, 0);
        idle(8);
        check("t5 el pre", int'(elapsed_time), 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5 el async", int'(elapsed_time), 0);
        check("t5 run async", int'(running), 0);
        check("t5 tick async", int'(sec_tick), 0);
        check("t5 up async", int'(time_up), 0);
        idle(2);
        rst_n = 1'b1;
        idle(10);
        check("t5 el after", int'(elapsed_time), 0);

`ifdef TIMER_BONUS_EN
        // 6: bonus saturation and coincident tick
        pulse(1, 0, 0, 0);
        idle(8);
        pulse(0, 0, 0, 1);                       // sampled at N+9
        check("t6 sat", int'(elapsed_time), 0);
        idle(10);
        pulse(0, 0, 0, 1);                       // sampled at N+20 with tick
        check("t6 coinc el", int'(elapsed_time), 0);
        check("t6 coinc up", int'(time_up), 0);
        check("t6 coinc run", int'(running), 1);
`endif

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_timer.md
Name: game_timer

Overview:
Per-round game clock for the reflex trainer. Converts the system clock into one-second ticks and counts elapsed seconds from 0 up to GAME_SECONDS under start, pause and stop control. Directly upstream of the on-screen time display: elapsed_time drives the display's 5-bit elapsed-time input, which renders GAME_SECONDS - elapsed_time. time_up tells the game FSM that the round is over.

Parameters:
CLK_HZ, 100000000, clk cycles per second tick; >= 2; tests use a small value.
GAME_SECONDS, 30, round length in seconds; 1..31.
BONUS_SECONDS, 3, seconds removed from elapsed_time per add_time pulse; used only with TIMER_BONUS_EN.

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begin or restart a round
pause_toggle  in  1  single-cycle pulse; RUN<->PAUSED
stop  in  1  single-cycle pulse; abort round, return to IDLE
elapsed_time  out  5  whole seconds elapsed in the current round, registered
running  out  1  high while state==RUN, registered
sec_tick  out  1  one-cycle pulse on each counted second, registered
time_up  out  1  one-cycle pulse when elapsed_time reaches GAME_SECONDS, registered
add_time  in  1  single-cycle pulse, bonus request (present only with TIMER_BONUS_EN)

Behaviour:
- Reset (async assert, sync-released by the system): state=IDLE, prescaler=0, elapsed_time=0, running=0, sec_tick=0, time_up=0. Reset mid-round discards the round immediately.
- States: IDLE, RUN, PAUSED, DONE. 2-bit encoded.
- Input priority per cycle: stop > start > pause_toggle. Lower-priority inputs in the same cycle are ignored.
- stop (any state): -> IDLE, elapsed_time=0, prescaler=0.
- start (any state, no stop): -> RUN, elapsed_time=0, prescaler=0. Restarts a running or paused round.
- pause_toggle: RUN -> PAUSED; PAUSED -> RUN. Ignored in IDLE/DONE. Prescaler and elapsed_time hold in PAUSED.
- Prescaler: width $clog2(CLK_HZ); increments only in RUN; at CLK_HZ-1 it wraps to 0 and produces a tick.
- Tick: elapsed_time+1 on the same edge as the wrap; sec_tick=1 for that cycle.
- Timing: start sampled at edge N -> elapsed_time==k from edge N+k*CLK_HZ (absent pauses). Pausing for P cycles delays later ticks by exactly P cycles.
- Completion: on the edge at which elapsed_time becomes GAME_SECONDS: state=DONE, running=0, time_up=1 for exactly one cycle, sec_tick=1 on the same cycle.
- DONE: elapsed_time holds GAME_SECONDS, so the display shows 0. Only start or stop leave DONE.
- running is 1 exactly while state==RUN; it changes on the same edge as the state.
- elapsed_time never exceeds GAME_SECONDS and never wraps.

Optional Feature:
TIMER_BONUS_EN
- Defined:
  - The add_time port exists.
  - An add_time pulse in RUN or PAUSED sets elapsed_time = max(0, elapsed_time + tick - BONUS_SECONDS), using a 6-bit intermediate. tick is 1 only if a tick occurs in that same cycle.
  - Same-cycle tick and add_time: DONE is entered only if the net result equals GAME_SECONDS.
  - add_time is ignored in IDLE/DONE and when stop or start is asserted in the same cycle.
- Undefined: no add_time port; BONUS_SECONDS has no effect.

Test Plan:
All scenarios use CLK_HZ=4, GAME_SECONDS=3.
1. Release rst_n, idle 10 cycles -> elapsed_time=0, running=0, time_up=0, sec_tick never pulses.
2. start at edge N -> elapsed_time=1@N+4, 2@N+8, 3@N+12; time_up=1 only in cycle N+12; state DONE with running=0 afterwards; elapsed_time stays 3.
3. start, then pause_toggle at N+2, pause_toggle again at N+12 -> elapsed_time stays 0 while paused; becomes 1 at N+14; time_up at N+22.
4. Same-cycle stop+start mid-round -> IDLE, elapsed_time=0, running=0. Next-cycle start alone -> RUN from 0. Same-cycle start+pause_toggle -> RUN, not paused.
5. Assert rst_n low at elapsed_time=2 mid-count -> all outputs 0 asynchronously, before the next clk edge; no time_up pulse.
6. (TIMER_BONUS_EN, BONUS_SECONDS=3) add_time at elapsed_time=2 -> 0 (saturated). add_time coincident with the tick to 3 -> elapsed_time=0, no time_up, stays RUN.
